// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MMU IO bus.
// TX FIFO feeds an IDLE/START/DATA/STOP serialiser.
module io_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  output logic        txd,
  output logic        irq_tx_empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_nxt;
  logic [15:0]    divisor, divc, dm1;
  logic [2:0]     bitc;
  logic [7:0]     shift;
  logic           enable, overflow;
  logic           hit, wr, wr_tx, fifo_full, fifo_empty, push, pop, bit_end, idle_nxt;
  logic [1:0]     sel;
  logic [3:0]     cnt4;
  logic           unused_bits;

  assign unused_bits = ^{io_addr[1:0], io_data_write[31:16]};

  assign hit        = (io_addr[7:4] == 4'h0);
  assign sel        = io_addr[3:2];
  assign wr         = io_en & io_we & hit;
  assign wr_tx      = wr & (sel == 2'd0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = wr_tx & ~fifo_full;
  assign bit_end    = (divc == 16'd0);
  // A frame may start from IDLE or straight out of the last STOP cycle.
  assign pop        = enable & ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_end));
  assign idle_nxt   = ((state == IDLE) | ((state == STOP) & bit_end)) & ~pop;
  assign count_nxt  = count + CW'(push) - CW'(pop);
  assign dm1        = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
  assign cnt4       = 4'(count);

  always_comb begin
    io_data_read = '0;
    if (io_en & ~io_we & hit) begin
      case (sel)
        2'd1:    io_data_read = {24'b0, cnt4, overflow, fifo_empty, fifo_full, state != IDLE};
        2'd2:    io_data_read = {16'b0, divisor};
        2'd3:    io_data_read = {31'b0, enable};
        default: io_data_read = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= io_data_write[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor  <= DIV_RESET;
      enable   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr & (sel == 2'd2)) divisor <= io_data_write[15:0];
      if (wr & (sel == 2'd3)) enable  <= io_data_write[0];
      if (wr_tx & fifo_full)                           overflow <= 1'b1;
      else if (wr & (sel == 2'd1) & io_data_write[3])  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      txd          <= 1'b1;
      irq_tx_empty <= 1'b1;
      divc         <= '0;
      bitc         <= '0;
      shift        <= '0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      count        <= count_nxt;
      irq_tx_empty <= (count_nxt == '0) & idle_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        shift  <= mem[rd_ptr];
        txd    <= 1'b0;
        divc   <= dm1;
        state  <= START;
      end else begin
        case (state)
          IDLE: txd <= 1'b1;
          START: begin
            if (bit_end) begin
              state <= DATA;
              txd   <= shift[0];
              bitc  <= '0;
              divc  <= dm1;
            end else divc <= divc - 16'd1;
          end
          DATA: begin
            if (bit_end) begin
              divc <= dm1;
              if (bitc == 3'd7) begin
                state <= STOP;
                txd   <= 1'b1;
              end else begin
                shift <= {1'b0, shift[7:1]};
                txd   <= shift[1];
                bitc  <= bitc + 3'd1;
              end
            end else divc <= divc - 16'd1;
          end
          STOP: begin
            if (bit_end) state <= IDLE;
            else         divc  <= divc - 16'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: a frame monitor decodes txd at the expected
// bit length and checks each byte against a queue filled as bytes are written.
module tb_io_uart_tx;
  logic        clk_tb = 1'b0;
  logic        reset;
  logic [7:0]  io_addr;
  logic        io_en, io_we;
  logic [31:0] io_data_write, io_data_read;
  logic        txd, irq_tx_empty;

  int   tests = 0, fails = 0, frames = 0, cur_div = 4;
  bit   mon_en = 1'b0;
  logic [7:0] sb_q[$];

  always #5 clk_tb = ~clk_tb;

  io_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
    .clk(clk_tb), .reset(reset), .io_addr(io_addr), .io_en(io_en), .io_we(io_we),
    .io_data_write(io_data_write), .io_data_read(io_data_read),
    .txd(txd), .irq_tx_empty(irq_tx_empty));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    io_addr = a; io_we = 1'b0; io_en = 1'b1;
    #1 d = io_data_read;
    io_en = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_addr = a; io_data_write = d; io_we = 1'b1; io_en = 1'b1;
    @(negedge clk_tb);
    io_en = 1'b0; io_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit sent);
    if (sent) sb_q.push_back(b);
    wr(8'h00, {24'b0, b});
  endtask

  task automatic measure_busy(output int cnt, output int first);
    logic [31:0] d;
    bit done = 1'b0;
    cnt = 0; first = -1;
    for (int i = 0; i < 2000; i++) begin
      rd(8'h04, d);
      if (d[0]) begin
        if (first < 0) first = i;
        cnt++;
      end else if (irq_tx_empty && d[2]) begin
        done = 1'b1;
        break;
      end
      @(negedge clk_tb);
    end
    if (!done) chk("busy_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (irq_tx_empty) begin done = 1'b1; break; end
      @(negedge clk_tb);
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk_tb);
  endtask

  // Frame monitor: start bit seen on a negedge sample, then every bit must hold cur_div samples.
  initial begin
    logic [7:0] byte_v;
    bit ok;
    forever begin
      @(negedge clk_tb);
      if (mon_en && !reset && txd === 1'b0) begin
        ok = 1'b1; byte_v = '0;
        for (int c = 1; c < cur_div; c++) begin
          @(negedge clk_tb);
          if (txd !== 1'b0) ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
          for (int c = 0; c < cur_div; c++) begin
            @(negedge clk_tb);
            if (c == 0) byte_v[b] = txd;
            else if (txd !== byte_v[b]) ok = 1'b0;
          end
        end
        for (int c = 0; c < cur_div; c++) begin
          @(negedge clk_tb);
          if (txd !== 1'b1) ok = 1'b0;
        end
        frames++;
        chk("frame_timing", {31'b0, ok}, 32'd1);
        tests++;
        assert (sb_q.size() != 0) else begin
          fails++;
          $error("FAIL frame_unexpected: observed 0x%0h required no frame", byte_v);
        end
        if (sb_q.size() != 0) chk("frame_byte", {24'b0, byte_v}, {24'b0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, first;
    bit stayed;
    logic [31:0] tr, ex;

    reset = 1'b1; io_en = 1'b0; io_we = 1'b0; io_addr = '0; io_data_write = '0;
    repeat (3) @(negedge clk_tb);
    #1;
    chk("rst_txd", {31'b0, txd}, 32'd1);
    chk("rst_irq", {31'b0, irq_tx_empty}, 32'd1);
    chk("rst_bus_idle", io_data_read, 32'd0);
    @(negedge clk_tb);
    reset = 1'b0;
    chk_rd("rst_status", 8'h04, 32'h04);
    chk_rd("rst_divisor", 8'h08, 32'd434);
    chk_rd("rst_ctrl", 8'h0C, 32'd0);

    // Reset in the middle of a frame
    wr(8'h08, 32'd4); wr(8'h0C, 32'd1);
    send(8'hA5, 1'b0);
    repeat (8) @(negedge clk_tb);
    #2 reset = 1'b1;
    #1;
    chk("midrst_txd", {31'b0, txd}, 32'd1);
    chk("midrst_irq", {31'b0, irq_tx_empty}, 32'd1);
    @(negedge clk_tb);
    reset = 1'b0;
    chk_rd("midrst_status", 8'h04, 32'h04);
    chk_rd("midrst_divisor", 8'h08, 32'd434);
    chk_rd("midrst_ctrl", 8'h0C, 32'd0);
    stayed = 1'b1;
    repeat (20) begin @(negedge clk_tb); if (txd !== 1'b1) stayed = 1'b0; end
    chk("midrst_txd_idle", {31'b0, stayed}, 32'd1);

    // Single byte, D = 4
    mon_en = 1'b1; cur_div = 4;
    wr(8'h08, 32'd4); wr(8'h0C, 32'd1);
    send(8'hA5, 1'b1);
    measure_busy(cnt, first);
    chk("single_busy_cycles", cnt, 32'd40);
    chk("single_latency", first, 32'd1);
    chk("single_irq", {31'b0, irq_tx_empty}, 32'd1);
    wait_idle(100);
    chk("single_frames", frames, 32'd1);

    // Back-to-back, D = 2
    cur_div = 2;
    wr(8'h08, 32'd2);
    send(8'h55, 1'b1); send(8'h0F, 1'b1);
    measure_busy(cnt, first);
    chk("b2b_busy_cycles", cnt, 32'd40);
    chk("b2b_first", first, 32'd0);
    wait_idle(100);
    chk("b2b_frames", frames, 32'd3);

    // Overflow: nine writes into a disabled 8-deep FIFO
    wr(8'h0C, 32'd0); cur_div = 1; wr(8'h08, 32'd1);
    for (int b = 0; b < 9; b++) send(8'(b), b < 8);
    chk_rd("ovf_status_full", 8'h04, 32'h8A);
    wr(8'h0C, 32'd1);
    wait_idle(500);
    chk("ovf_queue_drained", sb_q.size(), 32'd0);
    chk("ovf_frames", frames, 32'd11);
    chk_rd("ovf_status_sticky", 8'h04, 32'h0C);
    wr(8'h04, 32'h08);
    chk_rd("ovf_status_cleared", 8'h04, 32'h04);

    // DIVISOR = 0 behaves as 1
    wr(8'h08, 32'd0); cur_div = 1;
    send(8'h3C, 1'b1);
    measure_busy(cnt, first);
    chk("div0_busy_cycles", cnt, 32'd10);
    wait_idle(100);
    chk("div0_frames", frames, 32'd12);

    // DIVISOR 2 -> 3 written during data bit 1
    mon_en = 1'b0;
    wr(8'h08, 32'd2);
    send(8'h55, 1'b0);
    for (int i = 0; i < 32; i++) begin
      tr[i] = txd;
      if (i == 5) begin io_addr = 8'h08; io_data_write = 32'd3; io_we = 1'b1; io_en = 1'b1; end
      if (i == 6) begin io_en = 1'b0; io_we = 1'b0; end
      @(negedge clk_tb);
    end
    ex = '1;
    ex[1] = 1'b0; ex[2] = 1'b0;
    ex[5] = 1'b0; ex[6] = 1'b0;
    for (int b = 2; b < 8; b++)
      for (int k = 0; k < 3; k++) ex[7 + (b - 2) * 3 + k] = (b % 2 == 0);
    chk("div_midframe_trace", tr, ex);
    wait_idle(100);
    chk_rd("div_midframe_reg", 8'h08, 32'd3);

    // Address decode
    mon_en = 1'b1; cur_div = 3;
    wr(8'h48, 32'h1234);
    chk_rd("dec_div_unchanged", 8'h08, 32'd3);
    wr(8'h4C, 32'd0);
    chk_rd("dec_ctrl_unchanged", 8'h0C, 32'd1);
    wr(8'h40, 32'h77);
    chk_rd("dec_no_push", 8'h04, 32'h04);
    chk_rd("dec_read_10", 8'h10, 32'd0);
    chk_rd("dec_read_48", 8'h48, 32'd0);
    chk_rd("dec_low_bits_ignored", 8'h0B, 32'd3);
    io_addr = 8'h08; io_we = 1'b0; io_en = 1'b0;
    #1 chk("dec_no_en_read", io_data_read, 32'd0);
    repeat (50) @(negedge clk_tb);
    chk("dec_frames", frames, 32'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
